mw_sub_5bit: RTL and testbench
==============================

// Module: mw_sub_5bit
// PURPOSE
//   Multi-word subtractor: streams two NWORDS*5-bit operands as 5-bit limbs, LSW first,
//   and returns D = A - B limb by limb with borrow chained between limbs.
//   Each limb uses 5-bit borrow-lookahead logic (g=~a&b, p=~(a^b)), the inverse of the 5-bit CLA adder.
//   The block is the subtract path of the datapath, with a one-stage registered pipeline and valid/ready on both sides.
// PARAMETERS
//   NWORDS   4   limbs per operand, legal 2..16; operand width = 5*NWORDS
// PORTS
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   in_valid   in   1  limb pair on a_in/b_in is valid
//   in_ready   out  1  block accepts limb this cycle
//   in_first   in   1  limb is LSW of a new operand (qualified by in_valid)
//   a_in       in   5  minuend limb
//   b_in       in   5  subtrahend limb
//   out_valid  out  1  diff limb valid
//   out_ready  in   1  downstream accepts diff limb
//   diff       out  5  difference limb
//   out_last   out  1  diff is MSW (limb NWORDS-1)
//   bout       out  1  final borrow (A<B unsigned); meaningful when out_last=1
//   zero       out  1  entire D==0; meaningful when out_last=1
//   err        out  1  one-cycle pulse: protocol violation (see below)
// BEHAVIOUR
//   Reset: out_valid=0, diff=0, out_last=0, bout=0, zero=0, err=0, borrow=0, cnt=0, state=IDLE.
//     Asserting rst mid-operand discards the operand and any held output limb.
//   Accept: limb is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
//   Latency: accepted limb appears on diff exactly 1 cycle later. Output registers hold while out_valid && !out_ready.
//   Arithmetic per accepted limb: {b_next, diff} = a_in - b_in - bin, 5-bit wrap.
//     bin = 0 if in_first, else the stored borrow. The stored borrow updates to b_next on every accept.
//   FSM:
//     IDLE: accepted limb with in_first=1 -> processed as limb 0, cnt=1, go BUSY.
//       Accepted limb with in_first=0 -> dropped, no output, err pulses.
//     BUSY: accepted limb with in_first=0 -> processed, cnt++.
//       When this is limb NWORDS-1: out_last=1, cnt=0, go IDLE.
//       Accepted limb with in_first=1 -> current operand aborted, err pulses.
//       The new limb is processed as limb 0 of a new operand (bin=0, cnt=1), state stays BUSY.
//       Diff limbs already emitted are not recalled.
//   Flags, registered with the MSW limb:
//     bout = b_next of the MSW.
//     zero = 1 iff every diff limb of the operand is 0. Running AND is cleared on in_first.
//     out_last, bout and zero read 0 on non-MSW limbs.
//   Throughput: one limb per cycle while out_ready=1. Back-to-back operands need no idle cycle.
//   err is a single-cycle pulse in the accept cycle's next edge and is independent of out_ready.
// TESTING (NWORDS=2 unless noted; operand = {limb1,limb0})
//   37-10: limbs (5,1)-(10,0) -> diff 27 then 0; out_last on 2nd; bout=0, zero=0
//   0-1: limbs (0,0)-(1,0) -> diff 31, 31; bout=1, zero=0 (wrap, borrow ripples across limbs)
//   500-500: limbs (20,15)-(20,15) -> diff 0, 0; zero=1, bout=0
//   backpressure: out_ready=0 for 3 cycles after 1st limb -> diff=27 held, in_ready=0, no limb lost; resumes on out_ready=1
//   in_first re-asserted on 2nd limb -> err pulse, borrow cleared, next limb is treated as MSW of new operand
//   rst pulse mid-operand, then 0-1 -> flags/out_valid cleared; result 31, 31, bout=1; NWORDS=4 run: 4 limbs, out_last on 4th only

Source files
------------

// File: rtl/mw_sub_5bit.sv
// mw_sub_5bit: streaming multi-limb subtractor D = A - B, 5-bit limbs, LSW first.
// Ports: in_valid/in_ready/in_first/a_in/b_in limb input; out_valid/out_ready/diff/
//        out_last/bout/zero limb output with MSW flags; err protocol-violation pulse.
module mw_sub_5bit #(
   parameter int NWORDS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_first,
   input  logic [4:0] a_in,
   input  logic [4:0] b_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] diff,
   output logic       out_last,
   output logic       bout,
   output logic       zero,
   output logic       err
);
   localparam int CW = $clog2(NWORDS);
   localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          borrow_q;
   logic          zrun_q;
   logic          out_valid_q;
   logic [4:0]    diff_q;
   logic          out_last_q;
   logic          bout_q;
   logic          zero_q;
   logic          err_q;

   logic       acc;
   logic       proc;
   logic       bin;
   logic [4:0] g;
   logic [4:0] p;
   logic [5:0] c;
   logic [4:0] diff_d;
   logic       bnext_d;
   logic       zrun_d;
   logic       msw_d;

   assign in_ready = !out_valid_q || out_ready;
   assign acc      = in_valid && in_ready;
   // In IDLE only an in_first limb is processed; others are dropped.
   assign proc     = acc && (in_first || state_q == BUSY);
   assign bin      = in_first ? 1'b0 : borrow_q;

   // Borrow generate/propagate: borrow out of bit i when a<b, or a==b with borrow in.
   always_comb begin
      g    = ~a_in & b_in;
      p    = ~(a_in ^ b_in);
      c    = '0;
      c[0] = bin;
      for (int i = 0; i < 5; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      diff_d  = a_in ^ b_in ^ c[4:0];
      bnext_d = c[5];
   end

   assign zrun_d = (in_first ? 1'b1 : zrun_q) & (diff_d == 5'd0);
   assign msw_d  = !in_first && state_q == BUSY && cnt_q == LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         zrun_q      <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         out_last_q  <= 1'b0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (acc) begin
            unique case (state_q)
               IDLE: begin
                  if (in_first) begin
                     cnt_q   <= CW'(1);
                     state_q <= BUSY;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               BUSY: begin
                  if (in_first) begin
                     err_q <= 1'b1;
                     cnt_q <= CW'(1);
                  end else if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            endcase
         end
         if (proc) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
            borrow_q    <= bnext_d;
            zrun_q      <= zrun_d;
            out_last_q  <= msw_d;
            bout_q      <= msw_d & bnext_d;
            zero_q      <= msw_d & zrun_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign out_last  = out_last_q;
   assign bout      = bout_q;
   assign zero      = zero_q;
   assign err       = err_q;
endmodule

// File: tb/tb_mw_sub_5bit.sv
// tb_mw_sub_5bit: directed NWORDS=2 vectors and sequences, plus randomized
// NWORDS=4 streaming against an integer-arithmetic reference model.
module tb_mw_sub_5bit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       v2 = 0, ir2, f2 = 0, ov2, rdy2 = 1, last2, bo2, z2, e2;
   logic [4:0] a2 = 0, b2 = 0, d2;
   logic       v4 = 0, ir4, f4 = 0, ov4, rdy4 = 1, last4, bo4, z4, e4;
   logic [4:0] a4 = 0, b4 = 0, d4;

   mw_sub_5bit #(.NWORDS(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2),
      .in_first(f2), .a_in(a2), .b_in(b2), .out_valid(ov2),
      .out_ready(rdy2), .diff(d2), .out_last(last2), .bout(bo2),
      .zero(z2), .err(e2)
   );

   mw_sub_5bit #(.NWORDS(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4),
      .in_first(f4), .a_in(a4), .b_in(b4), .out_valid(ov4),
      .out_ready(rdy4), .diff(d4), .out_last(last4), .bout(bo4),
      .zero(z4), .err(e4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      int         a;
      int         b;
      logic [9:0] d;
      bit         bo;
      bit         z;
      string      nm;
   } vec_t;

   function automatic vec_t mk(input int a, input int b, input string nm);
      vec_t v;
      v.a  = a;
      v.b  = b;
      v.d  = 10'((a - b + 1024) % 1024);
      v.bo = (a < b);
      v.z  = (a == b);
      v.nm = nm;
      return v;
   endfunction

   task automatic limb2(input logic [4:0] a, input logic [4:0] b,
                        input bit f, input bit eov, input logic [4:0] ed,
                        input bit el, input bit eb, input bit ez,
                        input bit ee, input string nm);
      @(negedge clk);
      a2 = a; b2 = b; f2 = f; v2 = 1;
      @(negedge clk);
      v2 = 0; f2 = 0;
      chk({nm, ".ov"}, ov2, eov);
      if (eov) begin
         chk({nm, ".diff"}, d2, ed);
         chk({nm, ".last"}, last2, el);
         chk({nm, ".bout"}, bo2, eb);
         chk({nm, ".zero"}, z2, ez);
      end
      chk({nm, ".err"}, e2, ee);
   endtask

   task automatic reset_outs(input string nm);
      chk({nm, ".ov"}, ov2, 0);
      chk({nm, ".diff"}, d2, 0);
      chk({nm, ".last"}, last2, 0);
      chk({nm, ".bout"}, bo2, 0);
      chk({nm, ".zero"}, z2, 0);
      chk({nm, ".err"}, e2, 0);
   endtask

   typedef struct {
      logic [4:0] d;
      bit         l;
      bit         bo;
      bit         z;
   } exp_t;

   vec_t vt[3];

   initial begin
      vec_t       v;
      exp_t       q[$];
      exp_t       e;
      logic [19:0] ra, rb, dd;
      logic [9:0] av, bv;
      int         nops, li, cyc;
      bit         have;

      vt[0] = mk(37, 10, "v37m10");
      vt[1] = mk(0, 1, "v0m1");
      vt[2] = mk(500, 500, "v500m500");

      repeat (3) @(negedge clk);
      #1;
      reset_outs("rst");
      chk("rst.in_ready", ir2, 1);
      rst = 0;

      for (int i = 0; i < 3; i++) begin
         v  = vt[i];
         av = 10'(v.a);
         bv = 10'(v.b);
         limb2(av[4:0], bv[4:0], 1, 1, v.d[4:0], 0, 0, 0, 0,
               {v.nm, ".l0"});
         limb2(av[9:5], bv[9:5], 0, 1, v.d[9:5], 1, v.bo, v.z, 0,
               {v.nm, ".l1"});
      end

      // backpressure: limb 1 held on the input while out_ready is low
      @(negedge clk);
      a2 = 5; b2 = 10; f2 = 1; v2 = 1;
      @(negedge clk);
      a2 = 1; b2 = 0; f2 = 0; rdy2 = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.ov", ov2, 1);
         chk("bp.diff", d2, 27);
         chk("bp.in_ready", ir2, 0);
         @(negedge clk);
      end
      rdy2 = 1;
      @(negedge clk);
      v2 = 0;
      chk("bp.l1.ov", ov2, 1);
      chk("bp.l1.diff", d2, 0);
      chk("bp.l1.last", last2, 1);
      chk("bp.l1.bout", bo2, 0);
      @(negedge clk);
      chk("bp.drain", ov2, 0);

      // protocol violations
      limb2(3, 1, 0, 0, 0, 0, 0, 0, 1, "idle_drop");
      limb2(5, 10, 1, 1, 27, 0, 0, 0, 0, "abort.l0");
      limb2(3, 1, 1, 1, 2, 0, 0, 0, 1, "abort.restart");
      limb2(4, 1, 0, 1, 3, 1, 0, 0, 0, "abort.msw");

      // reset mid-operand
      limb2(5, 10, 1, 1, 27, 0, 0, 0, 0, "mid.l0");
      @(negedge clk);
      rst = 1;
      #1;
      reset_outs("mid.rst");
      @(negedge clk);
      rst = 0;
      limb2(0, 1, 1, 1, 31, 0, 0, 0, 0, "mid.0m1.l0");
      limb2(0, 0, 0, 1, 31, 1, 1, 0, 0, "mid.0m1.l1");

      // randomized NWORDS=4 streaming with random gaps and backpressure
      nops = 0; li = 0; cyc = 0; have = 0;
      ra = '0; rb = '0;
      while ((nops < 40 || have || q.size() != 0) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (!have && nops < 40) begin
            ra = 20'($urandom);
            rb = 20'($urandom);
            if ($urandom_range(0, 4) == 0) rb = ra;
            if ($urandom_range(0, 6) == 0) begin ra = 0; rb = 1; end
            dd = ra - rb;
            for (int k = 0; k < 4; k++) begin
               e.d  = dd[k*5 +: 5];
               e.l  = (k == 3);
               e.bo = (k == 3) && (ra < rb);
               e.z  = (k == 3) && (ra == rb);
               q.push_back(e);
            end
            have = 1; li = 0; nops++;
         end
         rdy4 = ($urandom_range(0, 3) != 0);
         if (have) begin
            v4 = ($urandom_range(0, 3) != 0);
            a4 = ra[li*5 +: 5];
            b4 = rb[li*5 +: 5];
            f4 = (li == 0);
         end else begin
            v4 = 0;
         end
         #1;
         if (ov4 && rdy4) begin
            if (q.size() == 0) begin
               chk("rnd.spurious", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rnd.diff", d4, e.d);
               chk("rnd.last", last4, e.l);
               chk("rnd.bout", bo4, e.bo);
               chk("rnd.zero", z4, e.z);
               chk("rnd.err", e4, 0);
            end
         end
         if (v4 && ir4) begin
            li++;
            if (li == 4) have = 0;
         end
      end
      if (cyc >= 5000) chk("rnd.timeout", cyc, 0);
      v4 = 0; rdy4 = 1;
      @(negedge clk);
      chk("rnd.drain", ov4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
